// File: rtl/dma_device_endpoint.sv
// Device-side endpoint of the 8237 single-transfer DMA handshake: raises DREQ,
// answers DACK plus IOR/IOW strobes, and buffers bytes in a small FIFO per direction.
//
//   state  | meaning
//   IDLE   | not armed; bus strobes are ignored
//   ARMED  | armed, waiting for DACK with the active strobe low
//   STROBE | strobe in progress; commit happens on its rising edge
module dma_device_endpoint #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       direction,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       dma_request,
    input  logic       dma_acknowledge_n,
    input  logic       io_read_n,
    input  logic       io_write_n,
    input  logic       terminal_count,
    input  logic [7:0] data_bus_in,
    output logic [7:0] data_bus_out,
    output logic       data_bus_out_enable
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STROBE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            dreq_q, dreq_d;
    logic            tc_q, tc_d;
    logic [7:0]      bus_q, bus_d;

    logic [7:0]      tx_mem_q [DEPTH];
    logic [7:0]      tx_mem_d [DEPTH];
    logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

    logic [7:0]      rx_mem_q [DEPTH];
    logic [7:0]      rx_mem_d [DEPTH];
    logic [PW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;

    logic            strobe_n;
    logic            tx_push, tx_pop;
    logic            rx_push, rx_pop;
    logic            inflight;

    // Only the strobe matching the latched direction moves the handshake.
    assign strobe_n = dir_q ? io_write_n : io_read_n;

    assign tx_ready = (tx_cnt_q != DEPTH_C);
    assign rx_valid = (rx_cnt_q != '0);
    assign tx_push  = tx_valid & tx_ready & ~abort;
    assign rx_pop   = rx_valid & rx_ready & ~abort;

    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign error               = error_q;
    assign dma_request         = dreq_q;
    assign data_bus_out        = (tx_cnt_q == '0) ? 8'hFF : tx_mem_q[tx_rd_q];
    assign data_bus_out_enable = ~dma_acknowledge_n & ~io_read_n & busy & ~dir_q;
    assign rx_data             = rx_valid ? rx_mem_q[rx_rd_q] : 8'h00;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        done_d   = done_q;
        error_d  = error_q;
        tc_d     = tc_q;
        bus_d    = bus_q;
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        inflight = 1'b0;
        dreq_d   = 1'b0;

        if (start) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    dir_d   = direction;
                    tc_d    = 1'b0;
                end
            end
            ARMED: begin
                if (!dma_acknowledge_n && !strobe_n) begin
                    state_d = STROBE;
                    bus_d   = data_bus_in;
                    tc_d    = terminal_count;
                end
            end
            STROBE: begin
                if (strobe_n) begin
                    state_d = tc_q ? IDLE : ARMED;
                    tc_d    = 1'b0;
                    if (tc_q) begin
                        done_d = 1'b1;
                    end
                    // An empty TX or full RX at the edge is a spurious strobe.
                    if (!dir_q) begin
                        if (tx_cnt_q != '0) begin
                            tx_pop = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        if (rx_cnt_q != DEPTH_C) begin
                            rx_push = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end else begin
                    bus_d = data_bus_in;
                    tc_d  = tc_q | terminal_count;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_push) begin
            tx_mem_d[tx_wr_q] = tx_data;
            tx_wr_d           = tx_wr_q + PW'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PW'(1);
        end
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

        if (rx_push) begin
            rx_mem_d[rx_wr_q] = bus_q;
            rx_wr_d           = rx_wr_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PW'(1);
        end
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        if (abort) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            error_d  = 1'b0;
            tc_d     = 1'b0;
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end

        // Next-cycle view so DREQ drops before the last byte/slot is consumed.
        inflight = (state_d == STROBE);
        if (dir_d) begin
            dreq_d = (DEPTH_C - rx_cnt_d) > CW'(inflight);
        end else begin
            dreq_d = tx_cnt_d > CW'(inflight);
        end
        if ((state_d == IDLE) || tc_d) begin
            dreq_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            dreq_q   <= 1'b0;
            tc_q     <= 1'b0;
            bus_q    <= 8'h00;
            tx_mem_q <= '{default: '0};
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_mem_q <= '{default: '0};
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            error_q  <= error_d;
            dreq_q   <= dreq_d;
            tc_q     <= tc_d;
            bus_q    <= bus_d;
            tx_mem_q <= tx_mem_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_mem_q <= rx_mem_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: tb/tb_dma_device_endpoint.sv
// Table-driven bench for dma_device_endpoint: one row per clock cycle of inputs
// and the outputs expected during that cycle, plus a hand-written reset-mid-strobe case.
module tb_dma_device_endpoint;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, abort, direction;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       busy, done, error, dma_request;
    logic       dma_acknowledge_n, io_read_n, io_write_n, terminal_count;
    logic [7:0] data_bus_in, data_bus_out;
    logic       data_bus_out_enable;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dma_device_endpoint #(.FIFO_DEPTH_LOG2(2)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start               (start),
        .abort               (abort),
        .direction           (direction),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .dma_request         (dma_request),
        .dma_acknowledge_n   (dma_acknowledge_n),
        .io_read_n           (io_read_n),
        .io_write_n          (io_write_n),
        .terminal_count      (terminal_count),
        .data_bus_in         (data_bus_in),
        .data_bus_out        (data_bus_out),
        .data_bus_out_enable (data_bus_out_enable)
    );

    // {busy, done, error, dreq, tx_ready, rx_valid, rx_data, data_bus_out, oe}
    logic [22:0] act_w;
    assign act_w = {busy, done, error, dma_request, tx_ready, rx_valid,
                    rx_data, data_bus_out, data_bus_out_enable};

    localparam logic [22:0] RST = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0};

    typedef struct {
        string       name;
        logic        st, ab, dir, txv;
        logic [7:0]  txd;
        logic        rxr, dack_n, ior_n, iow_n, tc;
        logic [7:0]  dbin;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic st, logic ab, logic dir, logic txv,
                                logic [7:0] txd, logic rxr, logic dack_n, logic ior_n,
                                logic iow_n, logic tc, logic [7:0] dbin,
                                logic e_busy, logic e_done, logic e_err, logic e_dreq,
                                logic e_txr, logic e_rxv, logic [7:0] e_rxd,
                                logic [7:0] e_dbo, logic e_oe);
        vec_t v;
        v.name = name; v.st = st; v.ab = ab; v.dir = dir; v.txv = txv; v.txd = txd;
        v.rxr = rxr; v.dack_n = dack_n; v.ior_n = ior_n; v.iow_n = iow_n; v.tc = tc;
        v.dbin = dbin;
        v.exp = {e_busy, e_done, e_err, e_dreq, e_txr, e_rxv, e_rxd, e_dbo, e_oe};
        return v;
    endfunction

    function automatic string fmt(logic [22:0] v);
        return $sformatf("busy=%0b done=%0b err=%0b dreq=%0b txr=%0b rxv=%0b rxd=%02h dbo=%02h oe=%0b",
                         v[22], v[21], v[20], v[19], v[18], v[17], v[16:9], v[8:1], v[0]);
    endfunction

    task automatic check(string nm, logic [22:0] exp);
        checks++;
        if (act_w !== exp) begin
            errors++;
            $display("FAIL %s actual %s required %s", nm, fmt(act_w), fmt(exp));
        end
    endtask

    task automatic apply(vec_t v);
        start = v.st; abort = v.ab; direction = v.dir;
        tx_valid = v.txv; tx_data = v.txd; rx_ready = v.rxr;
        dma_acknowledge_n = v.dack_n; io_read_n = v.ior_n; io_write_n = v.iow_n;
        terminal_count = v.tc; data_bus_in = v.dbin;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; direction = 0; tx_valid = 0; tx_data = 8'h00; rx_ready = 0;
        dma_acknowledge_n = 1; io_read_n = 1; io_write_n = 1; terminal_count = 0;
        data_bus_in = 8'h00;
    endtask

    initial begin
        //                 name               st ab di tv txd    rr dk ir iw tc dbin   | bz dn er dq tr rv rxd    dbo    oe
        // device -> memory
        vecs.push_back(mk("a_push12",         0, 0, 0, 1, 8'h12, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("a_push34",         0, 0, 0, 1, 8'h34, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h12, 0));
        vecs.push_back(mk("a_start",          1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h12, 0));
        vecs.push_back(mk("a_armed",          0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h12, 0));
        vecs.push_back(mk("a_s1_low",         0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h12, 1));
        vecs.push_back(mk("a_s1_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h12, 0));
        vecs.push_back(mk("a_gap",            0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h34, 0));
        vecs.push_back(mk("a_s2_low",         0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h34, 1));
        vecs.push_back(mk("a_s2_hold",        0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'h34, 1));
        vecs.push_back(mk("a_s2_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'h34, 0));
        vecs.push_back(mk("a_abort",          0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        // memory -> device; direction input held at 0 after start to show it is latched
        vecs.push_back(mk("b_idle",           0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("b_start",          1, 0, 1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("b_armed",          0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("b_w0_low",         0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA0, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("b_w0_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h55, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("b_w1_low",         0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA1, 1, 0, 0, 1, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_w1_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h55, 1, 0, 0, 1, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_w2_low",         0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA2, 1, 0, 0, 1, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_w2_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h55, 1, 0, 0, 1, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_w3_low",         0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'hA3, 1, 0, 0, 1, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_w3_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h55, 1, 0, 0, 0, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_pop_a0",         0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'hA0, 8'hFF, 0));
        vecs.push_back(mk("b_pop_a1",         0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA1, 8'hFF, 0));
        vecs.push_back(mk("b_pop_a2",         0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA2, 8'hFF, 0));
        vecs.push_back(mk("b_pop_a3",         0, 0, 0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA3, 8'hFF, 0));
        vecs.push_back(mk("b_abort",          0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        // terminal count on the second strobe
        vecs.push_back(mk("c_idle",           0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("c_push01",         0, 0, 0, 1, 8'h01, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("c_push02",         0, 0, 0, 1, 8'h02, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h01, 0));
        vecs.push_back(mk("c_push03",         0, 0, 0, 1, 8'h03, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h01, 0));
        vecs.push_back(mk("c_start",          1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h01, 0));
        vecs.push_back(mk("c_s1_low",         0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h01, 1));
        vecs.push_back(mk("c_s1_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h01, 0));
        vecs.push_back(mk("c_s2_low_tc",      0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h02, 1));
        vecs.push_back(mk("c_s2_high",        0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'h02, 0));
        vecs.push_back(mk("c_done",           0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 8'h03, 0));
        vecs.push_back(mk("c_restart",        1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 8'h03, 0));
        vecs.push_back(mk("c_rearmed_abort",  0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h03, 0));
        // spurious strobe with TX empty
        vecs.push_back(mk("d_idle",           0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("d_start",          1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("d_armed",          0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("d_low",            0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 1));
        vecs.push_back(mk("d_high",           0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("d_err_abort",      0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 1, 0, 1, 0, 8'h00, 8'hFF, 0));
        // strobe while idle
        vecs.push_back(mk("e_idle",           0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("e_idle_low",       0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("e_idle_high",      0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        // push coinciding with a strobe-edge pop, then fill to full
        vecs.push_back(mk("f_push11",         0, 0, 0, 1, 8'h11, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("f_push22",         0, 0, 0, 1, 8'h22, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h11, 0));
        vecs.push_back(mk("f_start",          1, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h11, 0));
        vecs.push_back(mk("f_low",            0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h11, 1));
        vecs.push_back(mk("f_high_push33",    0, 0, 0, 1, 8'h33, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h11, 0));
        vecs.push_back(mk("f_push44",         0, 0, 0, 1, 8'h44, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h22, 0));
        vecs.push_back(mk("f_push55",         0, 0, 0, 1, 8'h55, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h22, 0));
        vecs.push_back(mk("f_full_push66",    0, 0, 0, 1, 8'h66, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 8'h22, 0));
        vecs.push_back(mk("f_low2",           0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 8'h22, 1));
        vecs.push_back(mk("f_high2",          0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 8'h22, 0));
        vecs.push_back(mk("f_abort",          0, 1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'h33, 0));
        vecs.push_back(mk("f_flushed",        0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        // abort in the middle of an IOW strobe
        vecs.push_back(mk("g_start",          1, 0, 1, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("g_armed",          0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("g_low1",           0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h5A, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("g_high1",          0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("g_low2",           0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h77, 1, 0, 0, 1, 1, 1, 8'h5A, 8'hFF, 0));
        vecs.push_back(mk("g_abort_low",      0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h77, 1, 0, 0, 1, 1, 1, 8'h5A, 8'hFF, 0));
        vecs.push_back(mk("g_edge_ignored",   0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk("g_after",          0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF, 0));

        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset_values", RST);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            @(negedge clock);
            check(vecs[i].name, vecs[i].exp);
            @(posedge clock);
            #1;
        end

        // Reset pulled while IOW is low with DACK active.
        idle_inputs();
        tx_valid = 1; tx_data = 8'hAB;
        @(posedge clock); #1;
        tx_valid = 0; start = 1; direction = 1;
        @(posedge clock); #1;
        start = 0; direction = 0;
        dma_acknowledge_n = 0; io_write_n = 0; data_bus_in = 8'h99;
        @(posedge clock); #1;
        @(negedge clock);
        check("r_strobe_low", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hAB, 1'b0});
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        check("r_in_reset", RST);
        @(posedge clock); #1;
        reset_n = 1'b1;
        io_write_n = 1;
        @(negedge clock);
        check("r_edge_ignored", RST);
        @(posedge clock); #1;
        dma_acknowledge_n = 1;
        @(negedge clock);
        check("r_after", RST);
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_device_endpoint.md
# dma_device_endpoint

Device-side endpoint of the 8237 single-transfer DMA handshake: the peripheral end that raises DREQ and answers DACK and IOR/IOW strobes. It sits between a PCXT peripheral core (floppy, sound, etc.) and the DREQ/DACK/TC lines of the KF8237 controller. A small FIFO in each direction buffers device data. TC ends the armed transfer.

## Interface
- FIFO_DEPTH_LOG2, 2: each FIFO holds 2**FIFO_DEPTH_LOG2 bytes (depth 4 by default).
- clock  in  1  system clock; all bus inputs are synchronous to it.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms the endpoint and samples direction.
- abort  in  1  one-cycle pulse; disarms the endpoint and flushes both FIFOs.
- direction  in  1  0 = device→memory (DMA write, IOR strobe); 1 = memory→device (DMA read, IOW strobe).
- tx_data / tx_valid / tx_ready  in/in/out  8/1/1  device bytes to memory; a byte is pushed when valid & ready.
- rx_data / rx_valid / rx_ready  out/out/in  8/1/1  bytes from memory; a byte is popped when valid & ready.
- busy  out  1  endpoint is armed.
- done  out  1  sticky; TC was seen. Cleared by start or abort.
- error  out  1  sticky; spurious strobe seen. Cleared by start or abort.
- dma_request  out  1  DREQ, active high, registered.
- dma_acknowledge_n  in  1  DACK, active low.
- io_read_n, io_write_n  in  1  bus strobes, active low.
- terminal_count  in  1  TC, active high.
- data_bus_in  in  8  bus data, used in memory→device transfers.
- data_bus_out, data_bus_out_enable  out  8/1  bus data driver for device→memory transfers.

## Operation
- States: IDLE, ARMED, STROBE.
  - IDLE → ARMED on start. The direction is latched at this point and is ignored until the next start.
  - ARMED → STROBE when dma_acknowledge_n = 0 and the active strobe (IOR if direction = 0, IOW if direction = 1) = 0.
  - STROBE → ARMED on the strobe rising edge (strobe was low last cycle and is high now).
  - STROBE → IDLE on that same edge if terminal_count was 1 during the strobe.
  - abort → IDLE from any state and takes priority over every other event.
- Commit at the strobe rising edge:
  - direction 0: pop the TX FIFO.
  - direction 1: push the last data_bus_in value sampled while the strobe was low into the RX FIFO.
  - If TC was seen, done is set in the same cycle.
- Data bus (direction 0): data_bus_out = TX FIFO head, combinational. data_bus_out_enable = ~dma_acknowledge_n & ~io_read_n & busy & ~direction.
- DREQ:
  - Next value = busy & ~terminal-pending & (direction ? rx_free_eff > 0 : tx_count_eff > 0).
  - The `_eff` counts exclude the entry in flight while in STROBE, so DREQ falls before the last byte or last free slot is consumed.
- FIFO flow control:
  - tx_ready = TX FIFO not full.
  - rx_valid = RX FIFO not empty.
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo depth; count is FIFO_DEPTH_LOG2+1 bits.
- Spurious strobes:
  - A strobe in direction 0 with the TX FIFO empty: data_bus_out = 8'hFF, no pop, error is set.
  - A strobe in direction 1 with the RX FIFO full: the byte is dropped and error is set.
  - A strobe while IDLE: ignored, and data_bus_out_enable stays 0.
- abort or reset in the middle of a strobe: no commit happens, and the strobe edge that follows is ignored.
- Device-side pushes and pops continue in every state, including IDLE, except in the cycle where abort flushes the FIFOs.

## Timing
- Reset values:
  - dma_request = 0, data_bus_out_enable = 0, data_bus_out = 8'hFF (FIFO empty).
  - busy = 0, done = 0, error = 0.
  - tx_ready = 1, rx_valid = 0, rx_data = 8'h00.
  - State = IDLE; FIFOs empty.
- dma_request rises 1 cycle after its condition becomes true (for example, 1 cycle after start with data already in the TX FIFO). It falls 1 cycle after the condition becomes false.
- Commit latency: FIFO count, done and error update on the clock edge of the cycle in which the strobe rising edge is detected. rx_valid rises 1 cycle after the commit.
- data_bus_out and data_bus_out_enable are combinational: valid in the same cycle the strobe falls, hold until it rises.
- Minimum strobe width: 1 cycle. Back-to-back strobes with a single high cycle between them are each committed.

## Test plan
- Device→memory: push 8'h12, 8'h34; start with direction = 0 → DREQ high the next cycle. Two DACK+IOR pulses return 8'h12 then 8'h34 on data_bus_out; DREQ falls during the second strobe; error stays 0.
- Memory→device: start with direction = 1, TX FIFO ignored. Four IOW strobes carrying 8'hA0..8'hA3 → rx_data sequence A0..A3. DREQ falls during the fourth strobe (FIFO full at depth 4) and rises again after one rx pop.
- TC: direction 0, three bytes queued, TC asserted on the second strobe → done = 1, busy = 0, DREQ = 0. The third byte stays in the TX FIFO; a subsequent start re-raises DREQ.
- Spurious strobe: armed, direction 0, TX FIFO empty, DACK+IOR pulse → data_bus_out = 8'hFF, error = 1, TX count stays 0.
- Abort and reset mid-strobe: pull abort (and separately reset_n) low while IOW is low with DACK active → no RX push, busy = 0, FIFOs empty, all outputs at their reset values.
- Simultaneous events: a tx push in the same cycle as a strobe-edge pop with count = 2 → count stays 2 and byte order is preserved.
